// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic [4:0]       ALUControlE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             BusyE;
  logic             DoneE;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output StartE, ALUControlE, SrcAE, SrcBE,
    input  BusyE, DoneE, HI, LO
  );

  modport slave (
    input  StartE, ALUControlE, SrcAE, SrcBE,
    output BusyE, DoneE, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider writing HI/LO with a
// fixed 33-cycle latency; one operation in flight at a time.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         CLK,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam logic [4:0] OP_MUL  = 5'b00100;
  localparam logic [4:0] OP_MULU = 5'b10101;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_DIVU = 5'b10100;
  localparam logic [5:0] LAST    = 6'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [5:0]       cnt;
  logic             doneReg;
  logic [WIDTH-1:0] hiReg, loReg;
  logic [WIDTH-1:0] accHi;    // product high word / partial remainder
  logic [WIDTH-1:0] shLo;     // multiplier -> product low word / dividend -> quotient
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] srcARaw;
  logic             isDiv, negQ, negR, divZero;

  logic                    validOp, opIsDiv, opSigned;
  logic signed [WIDTH-1:0] srcA, srcB;
  logic [WIDTH-1:0]        magA, magB;
  logic [WIDTH:0]          mulSum;
  logic [WIDTH:0]          divShift;
  logic [WIDTH-1:0]        divDiff;
  logic                    divFits;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic signedOp);
    if (signedOp && v[WIDTH-1]) return negate(v);
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fixProduct(input logic [2*WIDTH-1:0] p,
                                                    input logic neg);
    if (neg) return ~p + (2*WIDTH)'(1);
    return p;
  endfunction

  always_comb begin
    validOp  = 1'b0;
    opIsDiv  = 1'b0;
    opSigned = 1'b0;
    unique case (bus.ALUControlE)
      OP_MUL:  begin validOp = 1'b1; opSigned = 1'b1; end
      OP_MULU: begin validOp = 1'b1; end
      OP_DIV:  begin validOp = 1'b1; opSigned = 1'b1; opIsDiv = 1'b1; end
      OP_DIVU: begin validOp = 1'b1; opIsDiv = 1'b1; end
      default: ;
    endcase
  end

  assign srcA = bus.SrcAE;
  assign srcB = bus.SrcBE;
  assign magA = magnitude(srcA, opSigned);
  assign magB = magnitude(srcB, opSigned);

  // One iteration of each datapath; the FSM picks which result to keep.
  assign mulSum   = shLo[0] ? ({1'b0, accHi} + {1'b0, opnd}) : {1'b0, accHi};
  assign divShift = {accHi, shLo[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, opnd};
  assign divDiff  = divShift[WIDTH-1:0] - opnd;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      doneReg <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      accHi   <= '0;
      shLo    <= '0;
      opnd    <= '0;
      srcARaw <= '0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.StartE && validOp) begin
            state   <= opIsDiv ? DIV : MUL;
            cnt     <= '0;
            isDiv   <= opIsDiv;
            srcARaw <= bus.SrcAE;
            negQ    <= opSigned && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            negR    <= opSigned && srcA[WIDTH-1];
            divZero <= opIsDiv && (bus.SrcBE == '0);
            accHi   <= '0;
            opnd    <= opIsDiv ? magB : magA;
            shLo    <= opIsDiv ? magA : magB;
          end
        end
        MUL: begin
          {accHi, shLo} <= {mulSum, shLo[WIDTH-1:1]};
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          accHi <= divFits ? divDiff : divShift[WIDTH-1:0];
          shLo  <= {shLo[WIDTH-2:0], divFits};
          cnt   <= cnt + 6'd1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          // The signed-overflow divide falls out naturally: |MIN|/1 = MIN, and
          // negating MIN yields MIN again with a zero remainder.
          if (isDiv && divZero) begin
            loReg <= '1;
            hiReg <= srcARaw;
          end else if (isDiv) begin
            loReg <= negQ ? negate(shLo) : shLo;
            hiReg <= negR ? negate(accHi) : accHi;
          end else begin
            {hiReg, loReg} <= fixProduct({accHi, shLo}, negQ);
          end
          doneReg <= 1'b1;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BusyE = (state != IDLE);
  assign bus.DoneE = doneReg;
  assign bus.HI    = hiReg;
  assign bus.LO    = loReg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic
// reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [W-1:0] expHi = '0, expLo = '0;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.CLK(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    hi = '0; lo = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      5'b00100: begin sp = longint'(sa) * longint'(sb); {hi, lo} = sp; end
      5'b10101: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); {hi, lo} = up; end
      5'b00011: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = '0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      5'b10100: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin hi = expHi; lo = expLo; end
    endcase
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.StartE = 1'b1; bus.ALUControlE = op; bus.SrcAE = a; bus.SrcBE = b;
    @(negedge clk);
    bus.StartE = 1'b0;
  endtask

  // Called at the negedge after the accept edge; returns at the negedge
  // after the FIX edge. intrudeAt > 0 pulses a divu 9/3 request at that edge.
  task automatic finish(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int intrudeAt);
    int   busyCycles = 0;
    logic earlyDone = 1'b0;
    logic [W-1:0] h, l;
    model(op, a, b, h, l);
    for (int i = 0; i < 33; i++) begin
      if (bus.BusyE) busyCycles++;
      if (bus.DoneE) earlyDone = 1'b1;
      if (intrudeAt > 0 && i == intrudeAt - 1) begin
        bus.StartE = 1'b1; bus.ALUControlE = 5'b10100; bus.SrcAE = 9; bus.SrcBE = 3;
      end else begin
        bus.StartE = 1'b0;
      end
      @(negedge clk);
    end
    expHi = h; expLo = l;
    chk({tag, "_busyCycles"}, 64'(busyCycles), 64'd33);
    chk({tag, "_earlyDone"}, 64'(earlyDone), 64'd0);
    chk({tag, "_done"}, 64'(bus.DoneE), 64'd1);
    chk({tag, "_busyLow"}, 64'(bus.BusyE), 64'd0);
    chk({tag, "_HI"}, 64'(bus.HI), 64'(h));
    chk({tag, "_LO"}, 64'(bus.LO), 64'(l));
  endtask

  task automatic runOp(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    issue(op, a, b);
    finish(tag, op, a, b, 0);
    @(negedge clk);
    chk({tag, "_donePulse"}, 64'(bus.DoneE), 64'd0);
  endtask

  logic [4:0] opTab [4] = '{5'b00100, 5'b10101, 5'b00011, 5'b10100};

  initial begin
    logic       sawDone;
    logic [4:0] rop;
    logic [W-1:0] ra, rb;
    bus.StartE = 1'b0; bus.ALUControlE = '0; bus.SrcAE = '0; bus.SrcBE = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.BusyE), 64'd0);
    chk("rst_done", 64'(bus.DoneE), 64'd0);
    chk("rst_HI", 64'(bus.HI), 64'd0);
    chk("rst_LO", 64'(bus.LO), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    runOp("mulu_max", 5'b10101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulu_max_HIconst", 64'(bus.HI), 64'h0000_0000_FFFF_FFFE);
    chk("mulu_max_LOconst", 64'(bus.LO), 64'h0000_0000_0000_0001);
    runOp("mul_neg", 5'b00100, 32'hFFFF_FFF9, 32'h0000_0003);
    chk("mul_neg_LOconst", 64'(bus.LO), 64'h0000_0000_FFFF_FFEB);
    runOp("div_neg", 5'b00011, 32'hFFFF_FFF9, 32'h0000_0002);
    chk("div_neg_LOconst", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);
    chk("div_neg_HIconst", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    runOp("divu_100_7", 5'b10100, 32'd100, 32'd7);
    runOp("div_ovf", 5'b00011, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_LOconst", 64'(bus.LO), 64'h0000_0000_8000_0000);
    runOp("divu_zero", 5'b10100, 32'd5, 32'd0);
    chk("divu_zero_LOconst", 64'(bus.LO), 64'h0000_0000_FFFF_FFFF);
    runOp("div_zero_s", 5'b00011, 32'hFFFF_FF00, 32'd0);

    // Invalid code: no state change.
    issue(5'b00000, 32'd123, 32'd456);
    chk("inval_busy", 64'(bus.BusyE), 64'd0);
    @(negedge clk);
    chk("inval_HI", 64'(bus.HI), 64'(expHi));
    chk("inval_LO", 64'(bus.LO), 64'(expLo));

    // Start while busy is dropped; start in the DoneE cycle is accepted.
    issue(5'b10101, 32'd2, 32'd3);
    finish("hs_ignore", 5'b10101, 32'd2, 32'd3, 10);
    issue(5'b10100, 32'd9, 32'd3);
    finish("hs_doneStart", 5'b10100, 32'd9, 32'd3, 0);
    chk("hs_doneStart_LOconst", 64'(bus.LO), 64'd3);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    issue(5'b00100, 32'd5, 32'd5);
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.BusyE), 64'd0);
    chk("arst_HI", 64'(bus.HI), 64'd0);
    chk("arst_LO", 64'(bus.LO), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.DoneE || bus.BusyE) sawDone = 1'b1;
    end
    chk("arst_noDone", 64'(sawDone), 64'd0);
    expHi = '0; expLo = '0;
    runOp("post_rst_mul", 5'b00100, 32'd5, 32'd5);

    // Randomized operations, biased toward divide-by-zero and overflow.
    for (int n = 0; n < 14; n++) begin
      rop = opTab[$urandom_range(0, 3)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        default: ;
      endcase
      runOp($sformatf("rnd%0d", n), rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
